// File: rtl/hyp_lookup_arbiter.sv
// Round-robin arbiter sharing one hypotenuse-lookup datapath among NUM_REQ requesters.
// One lookup in flight; the tagged result returns over a valid/ready port with saturating stats.
module hyp_lookup_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int LAT     = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*8-1:0] req_x,
  input  logic [NUM_REQ*8-1:0] req_y,
  output logic [7:0]           lk_x,
  output logic [7:0]           lk_y,
  input  logic [7:0]           lk_result,
  input  logic                 lk_valid,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [7:0]           rsp_data,
  output logic [ID_W-1:0]      rsp_id,
  output logic                 rsp_hit,
  output logic                 busy,
  output logic [15:0]          cnt_served,
  output logic [15:0]          cnt_miss
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state;
  logic [ID_W-1:0] last_grant;
  logic [ID_W-1:0] grant;
  logic            grant_found;
  logic [7:0]      sel_x;
  logic [7:0]      sel_y;
  logic [2:0]      wait_cnt;

  // Search starts one past the last winner; constant-index inner loop keeps selects width-clean.
  always_comb begin : arb
    int cand;
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    grant       = last_grant;
    grant_found = 1'b0;
    sel_x       = '0;
    sel_y       = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = (int'(last_grant) + i) % NUM_REQ;
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!grant_found && j == cand && req_valid[j]) begin
          grant       = ID_W'(j);
          grant_found = 1'b1;
          sel_x       = req_x[j*8 +: 8];
          sel_y       = req_y[j*8 +: 8];
        end
      end
    end
  end

  // Ready is gated by rst so nothing can appear accepted while the block is held in reset.
  always_comb begin
    req_ready = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!rst && state == IDLE && grant_found && ID_W'(j) == grant) req_ready[j] = 1'b1;
    end
  end

  assign busy = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= ID_W'(NUM_REQ - 1);
      wait_cnt   <= '0;
      lk_x       <= '0;
      lk_y       <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_id     <= '0;
      rsp_hit    <= 1'b0;
      cnt_served <= '0;
      cnt_miss   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            lk_x       <= sel_x;
            lk_y       <= sel_y;
            rsp_id     <= grant;
            last_grant <= grant;
            wait_cnt   <= 3'(LAT);
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt != 3'd0) begin
            wait_cnt <= wait_cnt - 3'd1;
          end else if (lk_valid) begin
            rsp_data  <= lk_result;
            rsp_hit   <= (lk_result != 8'd0);
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (cnt_served != 16'hFFFF) cnt_served <= cnt_served + 16'd1;
            if (!rsp_hit && cnt_miss != 16'hFFFF) cnt_miss <= cnt_miss + 16'd1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hyp_lookup_arbiter.sv
// Scoreboard bench for hyp_lookup_arbiter: directed scenarios plus random traffic,
// checked at negedge against a transaction-level reference model.
module tb_hyp_lookup_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int LAT     = 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*8-1:0] req_x;
  logic [NUM_REQ*8-1:0] req_y;
  logic [7:0]           lk_x, lk_y, lk_result;
  logic                 lk_valid;
  logic                 rsp_valid, rsp_ready, rsp_hit, busy;
  logic [7:0]           rsp_data;
  logic [ID_W-1:0]      rsp_id;
  logic [15:0]          cnt_served, cnt_miss;
  logic                 lk_en;

  hyp_lookup_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_y(req_y),
    .lk_x(lk_x), .lk_y(lk_y), .lk_result(lk_result), .lk_valid(lk_valid),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .rsp_hit(rsp_hit), .busy(busy),
    .cnt_served(cnt_served), .cnt_miss(cnt_miss)
  );

  always #5 clk = ~clk;

  // Integer-right-triangle table: hypotenuse if x^2+y^2 is a perfect square below 256, else 0.
  function automatic logic [7:0] hyp_ref(input logic [7:0] a, input logic [7:0] b);
    int s;
    s = int'(a) * int'(a) + int'(b) * int'(b);
    for (int c = 1; c < 256; c++) if (c * c == s) return 8'(c);
    return 8'd0;
  endfunction

  always_comb lk_result = hyp_ref(lk_x, lk_y);
  assign lk_valid = lk_en;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [ID_W-1:0] id;
    logic [7:0]      x;
    logic [7:0]      y;
    logic [7:0]      data;
  } exp_t;

  typedef enum {PH_IDLE, PH_WAIT, PH_RESP} ph_t;

  exp_t             sb[$];
  int               grant_log[$];
  int               rsp_log[$];
  ph_t              ph = PH_IDLE;
  int               acc_cnt = 0;
  int               k = 0;
  bit               pred = 1'b0;
  int               m_last = NUM_REQ - 1;
  int               m_served = 0;
  int               m_miss = 0;
  int               g;
  logic [NUM_REQ-1:0] er;

  // Monitor: reference model advanced once per cycle, compared at the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      check("rst_outputs", {req_ready, rsp_valid, busy, rsp_hit, rsp_id, rsp_data, lk_x, lk_y}, 64'd0);
      check("rst_counters", {cnt_served, cnt_miss}, 64'd0);
      sb.delete();
      ph       = PH_IDLE;
      m_last   = NUM_REQ - 1;
      m_served = 0;
      m_miss   = 0;
    end else begin
      if (ph == PH_IDLE) begin
        check("idle_busy_valid", {busy, rsp_valid}, 64'd0);
        check("idle_counters", {cnt_served, cnt_miss}, {16'(m_served), 16'(m_miss)});
        g  = -1;
        er = '0;
        for (int i = 1; i <= NUM_REQ; i++)
          if (g < 0 && req_valid[(m_last + i) % NUM_REQ]) g = (m_last + i) % NUM_REQ;
        if (g >= 0) er[g] = 1'b1;
        check("grant", req_ready, er);
        if (g >= 0) begin
          sb.push_back('{id: ID_W'(g), x: req_x[g*8 +: 8], y: req_y[g*8 +: 8],
                         data: hyp_ref(req_x[g*8 +: 8], req_y[g*8 +: 8])});
          grant_log.push_back(g);
          m_last = g;
          acc_cnt++;
          ph   = PH_WAIT;
          k    = 0;
          pred = 1'b0;
        end
      end else if (ph == PH_WAIT) begin
        check("wait_busy", busy, 64'd1);
        check("wait_ready", req_ready, 64'd0);
        if (sb.size() > 0) check("lk_operands", {lk_x, lk_y}, {sb[0].x, sb[0].y});
        check("rsp_timing", rsp_valid, pred);
        if (rsp_valid) begin
          ph = PH_RESP;
        end else begin
          k++;
          pred = (k >= LAT + 1) && lk_en;
        end
      end
      if (ph == PH_RESP) begin
        check("resp_valid", rsp_valid, 64'd1);
        check("resp_ready_low", req_ready, 64'd0);
        check("resp_counters", {cnt_served, cnt_miss}, {16'(m_served), 16'(m_miss)});
        if (sb.size() > 0)
          check("resp_payload", {rsp_id, rsp_data, rsp_hit}, {sb[0].id, sb[0].data, sb[0].data != 8'd0});
        if (rsp_ready && sb.size() > 0) begin
          rsp_log.push_back(int'(sb[0].data));
          if (m_served < 65535) m_served++;
          if (sb[0].data == 8'd0 && m_miss < 65535) m_miss++;
          void'(sb.pop_front());
          ph = PH_IDLE;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst(input int n);
    rst = 1'b1;
    repeat (n) step();
    rst = 1'b0;
  endtask

  task automatic set_ops(input int id, input logic [7:0] x, input logic [7:0] y);
    req_x[id*8 +: 8] = x;
    req_y[id*8 +: 8] = y;
  endtask

  task automatic issue(input int id, input logic [7:0] x, input logic [7:0] y);
    int start;
    int n;
    start = acc_cnt;
    n     = 0;
    set_ops(id, x, y);
    req_valid[id] = 1'b1;
    while (acc_cnt == start && n < 200) begin
      step();
      n++;
    end
    req_valid[id] = 1'b0;
    check("accept", acc_cnt - start, 64'd1);
  endtask

  task automatic wait_accepts(input int cnt);
    int start;
    int n;
    start = acc_cnt;
    n     = 0;
    while (acc_cnt - start < cnt && n < 300) begin
      step();
      n++;
    end
    req_valid = '0;
    check("accept_count", acc_cnt - start, cnt);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((ph != PH_IDLE || sb.size() != 0) && n < budget) begin
      step();
      n++;
    end
    check("drain", sb.size(), 64'd0);
  endtask

  logic [7:0] tx [8] = '{8'd3, 8'd5, 8'd8, 8'd7, 8'd20, 8'd60, 8'd13, 8'd1};
  logic [7:0] ty [8] = '{8'd4, 8'd12, 8'd15, 8'd24, 8'd21, 8'd80, 8'd84, 8'd1};

  initial begin
    int n;
    rst       = 1'b1;
    req_valid = '0;
    req_x     = '0;
    req_y     = '0;
    rsp_ready = 1'b1;
    lk_en     = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();

    // Single pythagorean request from requester 0.
    issue(0, 8'd3, 8'd4);
    wait_idle(50);
    check("t1_counts", {cnt_served, cnt_miss}, {16'd1, 16'd0});

    // Non-triple from requester 2 counts as a miss.
    issue(2, 8'd1, 8'd1);
    wait_idle(50);
    check("t2_counts", {cnt_served, cnt_miss}, {16'd2, 16'd1});
    check("t2_busy", busy, 64'd0);

    // All four requesters continuously valid after a fresh reset.
    pulse_rst(2);
    grant_log.delete();
    rsp_log.delete();
    set_ops(0, 8'd5, 8'd12);
    set_ops(1, 8'd8, 8'd15);
    set_ops(2, 8'd60, 8'd80);
    set_ops(3, 8'd13, 8'd84);
    req_valid = '1;
    wait_accepts(5);
    wait_idle(50);
    check("t4_order", {grant_log[0][7:0], grant_log[1][7:0], grant_log[2][7:0],
                       grant_log[3][7:0], grant_log[4][7:0]}, 40'h00_01_02_03_00);
    check("t4_results", {rsp_log[0][7:0], rsp_log[1][7:0], rsp_log[2][7:0], rsp_log[3][7:0]},
          {8'd13, 8'd17, 8'd100, 8'd85});

    // Backpressure: response held for six cycles.
    rsp_ready = 1'b0;
    issue(1, 8'd7, 8'd24);
    n = 0;
    while (ph != PH_RESP && n < 50) begin
      step();
      n++;
    end
    repeat (6) step();
    check("t5_held_data", rsp_data, 64'd25);
    rsp_ready = 1'b1;
    wait_idle(50);
    check("t5_counts", {cnt_served, cnt_miss}, {16'd6, 16'd0});

    // Lookup stall in WAIT.
    lk_en = 1'b0;
    issue(3, 8'd20, 8'd21);
    repeat (4) step();
    lk_en = 1'b1;
    wait_idle(50);
    check("t6_counts", {cnt_served, cnt_miss}, {16'd7, 16'd0});

    // Reset during WAIT with requesters 0 and 1 both pending.
    issue(0, 8'd9, 8'd12);
    set_ops(0, 8'd3, 8'd4);
    set_ops(1, 8'd6, 8'd8);
    req_valid = 4'b0011;
    pulse_rst(2);
    grant_log.delete();
    wait_accepts(2);
    wait_idle(50);
    check("t7_order", {grant_log[0][7:0], grant_log[1][7:0]}, 16'h00_01);
    check("t7_counts", {cnt_served, cnt_miss}, {16'd2, 16'd0});

    // Random traffic.
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        int t;
        req_valid[i] = ($urandom_range(0, 2) == 0);
        if ($urandom_range(0, 1) == 0) begin
          t = $urandom_range(0, 7);
          set_ops(i, tx[t], ty[t]);
        end else begin
          set_ops(i, 8'($urandom), 8'($urandom));
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      lk_en     = ($urandom_range(0, 7) != 0);
      step();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    lk_en     = 1'b1;
    wait_idle(100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
